oit_debouncer: RTL and testbench

- Conditions a raw asynchronous input (push-button, external strobe) into a clean, clock-synchronous level with single-cycle edge pulses.
- Sits directly upstream of the binary counter and latch primitives. Its `rise` pulse is the intended increment/enable source for a counter stage, and `out` is the intended level for a latch stage.
- Contains a synchronizer chain, a stability counter and a two-state FSM.

---
 rtl/oit_debouncer.sv | 155 +++++++++++++++
 tb/tb_oit_debouncer.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/oit_debouncer.sv
// oit_debouncer: synchronizes a raw asynchronous input, qualifies level changes
// over STABLE_CYCLES consecutive synchronized cycles and emits one-cycle
// rise/fall pulses alongside the clean level.
// Optional feature macro: OIT_DEBOUNCER_EVENT_COUNT_EN adds event_clear and a
// wrapping COUNT_WIDTH-bit count of rising events on event_count.
module oit_debouncer #(
    parameter int unsigned STABLE_CYCLES = 4,
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned RESET_LEVEL   = 0,
    parameter int unsigned COUNT_WIDTH   = 8
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   in,
`ifdef OIT_DEBOUNCER_EVENT_COUNT_EN
    input  logic                   event_clear,
    output logic [COUNT_WIDTH-1:0] event_count,
`endif
    output logic                   out,
    output logic                   rise,
    output logic                   fall,
    output logic                   busy
);

    localparam int unsigned CNT_W = (STABLE_CYCLES < 2) ? 1 : $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic RST_LVL = 1'(RESET_LEVEL);

    // Reject illegal parameterizations at elaboration time
    generate
        if (STABLE_CYCLES < 1 || STABLE_CYCLES > 65535) begin : g_bad_stable
            $error("oit_debouncer: STABLE_CYCLES must be in 1..65535");
        end
        if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
            $error("oit_debouncer: SYNC_STAGES must be in 2..4");
        end
        if (RESET_LEVEL > 1) begin : g_bad_level
            $error("oit_debouncer: RESET_LEVEL must be 0 or 1");
        end
        if (COUNT_WIDTH < 1) begin : g_bad_count
            $error("oit_debouncer: COUNT_WIDTH must be at least 1");
        end
    endgenerate

    typedef enum logic {
        ST_STABLE = 1'b0,
        ST_CHECK  = 1'b1
    } state_t;

    logic [SYNC_STAGES-1:0] sync_stage_q, sync_stage_d;
    logic                   sync_q;
    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   out_q, out_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;
    logic                   busy_q, busy_d;

    assign sync_q = sync_stage_q[SYNC_STAGES-1];

    // Plain shift chain; stage 0 samples the raw input
    always_comb begin
        sync_stage_d = {sync_stage_q[SYNC_STAGES-2:0], in};
    end

    // Qualification FSM, stability counter and edge pulse generation
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        out_d   = out_q;
        case (state_q)
            ST_STABLE: begin
                cnt_d = '0;
                if (sync_q != out_q) begin
                    if (STABLE_CYCLES == 1) begin
                        out_d = ~out_q;
                    end else begin
                        state_d = ST_CHECK;
                        cnt_d   = CNT_W'(1);
                    end
                end
            end
            ST_CHECK: begin
                if (sync_q == out_q) begin
                    state_d = ST_STABLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    out_d   = ~out_q;
                    state_d = ST_STABLE;
                    cnt_d   = '0;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_STABLE;
                cnt_d   = '0;
            end
        endcase
        rise_d = out_d & ~out_q;
        fall_d = ~out_d & out_q;
        busy_d = (state_d == ST_CHECK);
    end

    // State registers; reset aborts any qualification in progress
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_stage_q <= {SYNC_STAGES{RST_LVL}};
            state_q      <= ST_STABLE;
            cnt_q        <= '0;
            out_q        <= RST_LVL;
            rise_q       <= 1'b0;
            fall_q       <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            sync_stage_q <= sync_stage_d;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            out_q        <= out_d;
            rise_q       <= rise_d;
            fall_q       <= fall_d;
            busy_q       <= busy_d;
        end
    end

    assign out  = out_q;
    assign rise = rise_q;
    assign fall = fall_q;
    assign busy = busy_q;

`ifdef OIT_DEBOUNCER_EVENT_COUNT_EN
    logic [COUNT_WIDTH-1:0] event_count_q, event_count_d;

    // Count rise pulses one cycle late; a clear never drops a coincident rise
    always_comb begin
        event_count_d = event_count_q + COUNT_WIDTH'(rise_q);
        if (event_clear) begin
            event_count_d = COUNT_WIDTH'(rise_q);
        end
    end

    // Event counter register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            event_count_q <= '0;
        end else begin
            event_count_q <= event_count_d;
        end
    end

    assign event_count = event_count_q;
`endif

endmodule

// File: tb/tb_oit_debouncer.sv
// Bench for oit_debouncer: table-driven directed vectors, hand-written corner
// sequences and a randomized run against a window-based reference model.
module tb_oit_debouncer;

    localparam int unsigned R_S    = 3;
    localparam int unsigned R_SYNC = 3;
    localparam bit          R_RL   = 1'b1;
    localparam int          N_RAND = 3000;

    logic clk = 1'b0;
    logic reset;
    logic in0, in1, in_r;
    logic out0, rise0, fall0, busy0;
    logic out1, rise1, fall1, busy1;
    logic out_r, rise_r, fall_r, busy_r;
    logic       ev_clear0, ev_clear1, ev_clear_r;
    logic [1:0] ev_count0;
    logic [7:0] ev_count1, ev_count_r;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    oit_debouncer #(.STABLE_CYCLES(4), .SYNC_STAGES(2), .RESET_LEVEL(0), .COUNT_WIDTH(2)) u_dut0 (
        .clock(clk), .reset(reset), .in(in0),
`ifdef OIT_DEBOUNCER_EVENT_COUNT_EN
        .event_clear(ev_clear0), .event_count(ev_count0),
`endif
        .out(out0), .rise(rise0), .fall(fall0), .busy(busy0)
    );

    oit_debouncer #(.STABLE_CYCLES(1), .SYNC_STAGES(2), .RESET_LEVEL(0), .COUNT_WIDTH(8)) u_dut1 (
        .clock(clk), .reset(reset), .in(in1),
`ifdef OIT_DEBOUNCER_EVENT_COUNT_EN
        .event_clear(ev_clear1), .event_count(ev_count1),
`endif
        .out(out1), .rise(rise1), .fall(fall1), .busy(busy1)
    );

    oit_debouncer #(.STABLE_CYCLES(R_S), .SYNC_STAGES(R_SYNC), .RESET_LEVEL(1), .COUNT_WIDTH(8)) u_dutr (
        .clock(clk), .reset(reset), .in(in_r),
`ifdef OIT_DEBOUNCER_EVENT_COUNT_EN
        .event_clear(ev_clear_r), .event_count(ev_count_r),
`endif
        .out(out_r), .rise(rise_r), .fall(fall_r), .busy(busy_r)
    );

    typedef struct {
        logic in;
        logic out;
        logic rise;
        logic fall;
        logic busy;
    } vec_t;

    vec_t vt[20];

    // Input samples of the random run, indexed by clock edge after reset release
    bit hist[0:N_RAND+8];

    function automatic vec_t mk(input logic i, input logic o, input logic r, input logic f, input logic b);
        vec_t v;
        v.in = i; v.out = o; v.rise = r; v.fall = f; v.busy = b;
        return v;
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] want);
        n_vec++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, want, $time);
        end
    endtask

    // Hold reset over two edges, release one time unit after a rising edge
    task automatic apply_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // Value the qualifier sees at edge k: the input sampled R_SYNC edges earlier
    function automatic bit seen(input int k);
        return (k - int'(R_SYNC) >= 1) ? hist[k - int'(R_SYNC)] : R_RL;
    endfunction

`ifdef OIT_DEBOUNCER_EVENT_COUNT_EN
    // Raise in0 and wait for the rise pulse (bounded)
    task automatic wait_rise0(input string name);
        bit got = 1'b0;
        in0 = 1'b1;
        for (int c = 0; c < 20 && !got; c++) begin
            @(posedge clk); #1;
            if (rise0) got = 1'b1;
        end
        check({name, "_rise_seen"}, 8'(got), 8'd1);
    endtask

    // Drop in0 and wait for the fall pulse (bounded), then idle briefly
    task automatic wait_fall0(input string name);
        bit got = 1'b0;
        in0 = 1'b0;
        for (int c = 0; c < 20 && !got; c++) begin
            @(posedge clk); #1;
            if (fall0) got = 1'b1;
        end
        check({name, "_fall_seen"}, 8'(got), 8'd1);
        repeat (2) @(posedge clk);
        #1;
    endtask
`endif

    initial begin
        reset = 1'b1;
        in0 = 1'b1; in1 = 1'b0; in_r = 1'b1;
        ev_clear0 = 1'b0; ev_clear1 = 1'b0; ev_clear_r = 1'b0;

        // Directed table for the default configuration, one entry per edge
        for (int i = 0; i < 7; i++)   vt[i] = mk(1, 0, 0, 0, 0);
        for (int i = 2; i < 5; i++)   vt[i] = mk(1, 0, 0, 0, 1);
        vt[5] = mk(1, 1, 1, 0, 0);
        vt[6] = mk(1, 1, 0, 0, 0);
        vt[7] = mk(0, 1, 0, 0, 0);
        vt[8] = mk(0, 1, 0, 0, 0);
        vt[9] = mk(0, 1, 0, 0, 1);
        vt[10] = mk(1, 1, 0, 0, 1);
        vt[11] = mk(1, 1, 0, 0, 1);
        vt[12] = mk(1, 1, 0, 0, 0);
        vt[13] = mk(0, 1, 0, 0, 0);
        vt[14] = mk(0, 1, 0, 0, 0);
        for (int i = 15; i < 18; i++) vt[i] = mk(0, 1, 0, 0, 1);
        vt[18] = mk(0, 0, 0, 1, 0);
        vt[19] = mk(0, 0, 0, 0, 0);

        // Reset held with in=1: nothing may move
        repeat (2) @(posedge clk);
        #1;
        check("reset_dut0", {4'b0, out0, rise0, fall0, busy0}, 8'h00);
        check("reset_dutr_level", {7'b0, out_r}, 8'h01);
        check("reset_dut1", {4'b0, out1, rise1, fall1, busy1}, 8'h00);
        reset = 1'b0;

        for (int i = 0; i < 20; i++) begin
            in0 = vt[i].in;
            @(posedge clk); #1;
            check($sformatf("table_edge%0d", i + 1), {4'b0, out0, rise0, fall0, busy0},
                  {4'b0, vt[i].out, vt[i].rise, vt[i].fall, vt[i].busy});
        end

        // STABLE_CYCLES=1: out follows after edge 3, busy never asserts
        in1 = 1'b0;
        apply_reset();
        in1 = 1'b1;
        for (int e = 1; e <= 4; e++) begin
            @(posedge clk); #1;
            check($sformatf("s1_rise_edge%0d", e), {4'b0, out1, rise1, fall1, busy1},
                  (e < 3) ? 8'h00 : ((e == 3) ? 8'h0c : 8'h08));
        end
        in1 = 1'b0;
        for (int e = 1; e <= 4; e++) begin
            @(posedge clk); #1;
            check($sformatf("s1_fall_edge%0d", e), {4'b0, out1, rise1, fall1, busy1},
                  (e < 3) ? 8'h08 : ((e == 3) ? 8'h02 : 8'h00));
        end

        // Asynchronous reset while qualifying a fall with out=1
        in0 = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        check("async_pre_out", {7'b0, out0}, 8'h01);
        in0 = 1'b0;
        begin
            bit got = 1'b0;
            for (int c = 0; c < 10 && !got; c++) begin
                @(posedge clk); #1;
                if (busy0) got = 1'b1;
            end
            check("async_busy_seen", 8'(got), 8'd1);
        end
        #2;
        reset = 1'b1;
        #1;
        check("async_reset_now", {4'b0, out0, rise0, fall0, busy0}, 8'h00);
        apply_reset();
        repeat (3) @(posedge clk);
        #1;
        check("async_after_release", {4'b0, out0, rise0, fall0, busy0}, 8'h00);

`ifdef OIT_DEBOUNCER_EVENT_COUNT_EN
        // Wrapping 2-bit event count over five clean rising events
        in0 = 1'b0;
        apply_reset();
        check("evt_reset", {6'b0, ev_count0}, 8'h00);
        for (int i = 0; i < 5; i++) begin
            wait_rise0($sformatf("evt%0d", i));
            @(posedge clk); #1;
            check($sformatf("evt_count%0d", i), {6'b0, ev_count0}, 8'((i + 1) % 4));
            wait_fall0($sformatf("evt%0d", i));
        end
        // Plain clear
        ev_clear0 = 1'b1;
        @(posedge clk); #1;
        ev_clear0 = 1'b0;
        check("evt_clear", {6'b0, ev_count0}, 8'h00);
        for (int i = 0; i < 2; i++) begin
            wait_rise0("evt_pre");
            wait_fall0("evt_pre");
        end
        check("evt_pre_coincide", {6'b0, ev_count0}, 8'h02);
        // Clear coinciding with a rise pulse keeps that event
        wait_rise0("evt_co");
        ev_clear0 = 1'b1;
        @(posedge clk); #1;
        ev_clear0 = 1'b0;
        check("evt_clear_coincide", {6'b0, ev_count0}, 8'h01);
        wait_fall0("evt_co");
`endif

        // Randomized run against the window model (STABLE=3, SYNC=3, RESET_LEVEL=1)
        in_r = R_RL;
        apply_reset();
        begin
            bit m_out = R_RL;
            int last_t = 0;
            int run = 0;
            for (int k = 1; k <= N_RAND; k++) begin
                bit tog, mism, r, f, b;
                if (run == 0) begin
                    in_r = 1'($urandom_range(0, 1));
                    run = int'($urandom_range(1, 7));
                end
                run--;
                @(posedge clk);
                hist[k] = in_r;
                // out flips once the last R_S seen values all differ from it,
                // all of them after the previous flip
                tog = (k - last_t >= int'(R_S));
                for (int j = k - int'(R_S) + 1; j <= k; j++) begin
                    if (seen(j) == m_out) tog = 1'b0;
                end
                mism = (seen(k) != m_out);
                r = tog && !m_out;
                f = tog && m_out;
                b = mism && !tog;
                if (tog) begin
                    m_out = ~m_out;
                    last_t = k;
                end
                #1;
                check($sformatf("rand_edge%0d", k), {4'b0, out_r, rise_r, fall_r, busy_r},
                      {4'b0, m_out, r, f, b});
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
